// File: rtl/button_debounce_multi.sv
// Multi-channel button debouncer: 2-flop synchroniser, stability counter,
// press/release strobes and long-press detection per channel.
// The release strobe port is named rel because release is a reserved word.

module button_debounce_lane #(
   parameter int   DEBOUNCE_TOTAL = 120,
   parameter int   LONG_TOTAL     = 12000,
   parameter logic INV            = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic butd,
   output logic press,
   output logic rel,
   output logic long,
   output logic long_held
);

   localparam int DCW = $clog2(DEBOUNCE_TOTAL + 1);
   localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_TOTAL - 1);

   logic           sy1, sy2;
   logic [DCW-1:0] dc;
   logic           accept, rise, fall;

   // Synchroniser resets to "not pressed" in the post-inversion domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sy1 <= 1'b0;
         sy2 <= 1'b0;
      end else begin
         sy1 <= pin ^ INV;
         sy2 <= sy1;
      end
   end

   assign accept = (sy2 != butd) && (dc == DC_LAST);
   assign rise   = accept &  sy2;
   assign fall   = accept & ~sy2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dc    <= '0;
         butd  <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         press <= rise;
         rel   <= fall;
         if (sy2 == butd) begin
            dc <= '0;
         end else if (accept) begin
            butd <= sy2;
            dc   <= '0;
         end else begin
            dc <= dc + 1'b1;
         end
      end
   end

   generate
      if (LONG_TOTAL > 0) begin : g_long
         localparam int HCW = $clog2(LONG_TOTAL + 1);
         localparam logic [HCW-1:0] HC_LAST = HCW'(LONG_TOTAL - 1);
         localparam logic [HCW-1:0] HC_MAX  = HCW'(LONG_TOTAL);

         logic [HCW-1:0] hc;
         logic           hit;

         // A release accepted on the same edge suppresses the long strobe.
         assign hit = butd && !fall && (hc == HC_LAST);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hc        <= '0;
               long      <= 1'b0;
               long_held <= 1'b0;
            end else begin
               if (!butd || fall)
                  hc <= '0;
               else if (hc != HC_MAX)
                  hc <= hc + 1'b1;
               long      <= hit;
               long_held <= (long_held | hit) & ~fall;
            end
         end
      end else begin : g_no_long
         assign long      = 1'b0;
         assign long_held = 1'b0;
      end
   endgenerate

endmodule

module button_debounce_multi #(
   parameter int                   N_BUTTONS      = 4,
   parameter int                   DEBOUNCE_TOTAL = 120,
   parameter int                   LONG_TOTAL     = 12000,
   parameter logic [N_BUTTONS-1:0] INVERT         = {N_BUTTONS{1'b0}}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_BUTTONS-1:0] but,
   output logic [N_BUTTONS-1:0] butd,
   output logic [N_BUTTONS-1:0] press,
   output logic [N_BUTTONS-1:0] rel,
   output logic [N_BUTTONS-1:0] long,
   output logic [N_BUTTONS-1:0] long_held
);

   generate
      for (genvar i = 0; i < N_BUTTONS; i++) begin : g_lane
         button_debounce_lane #(
            .DEBOUNCE_TOTAL (DEBOUNCE_TOTAL),
            .LONG_TOTAL     (LONG_TOTAL),
            .INV            (INVERT[i])
         ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .pin       (but[i]),
            .butd      (butd[i]),
            .press     (press[i]),
            .rel       (rel[i]),
            .long      (long[i]),
            .long_held (long_held[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi: latency, bounce, glitch,
// long press, inversion, simultaneous channels and reset mid-hold.

module tb_button_debounce_multi;

   localparam int N  = 4;
   localparam int DT = 120;
   localparam int LT = 600;
   localparam logic [N-1:0] INV = 4'b1000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] but;
   logic [N-1:0] butd, press, rel, long, long_held;

   int checks = 0;
   int failures = 0;
   int press_cnt [N];
   int rel_cnt   [N];
   int long_cnt  [N];
   int both_cnt = 0;

   always #5 clk = ~clk;

   button_debounce_multi #(
      .N_BUTTONS      (N),
      .DEBOUNCE_TOTAL (DT),
      .LONG_TOTAL     (LT),
      .INVERT         (INV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .but       (but),
      .butd      (butd),
      .press     (press),
      .rel       (rel),
      .long      (long),
      .long_held (long_held)
   );

   initial begin
      for (int i = 0; i < N; i++) begin
         press_cnt[i] = 0;
         rel_cnt[i]   = 0;
         long_cnt[i]  = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (press[i]) press_cnt[i] = press_cnt[i] + 1;
         if (rel[i])   rel_cnt[i]   = rel_cnt[i] + 1;
         if (long[i])  long_cnt[i]  = long_cnt[i] + 1;
      end
      if ((press & rel) != '0) both_cnt = both_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0 butd rise, 1 butd fall, 2 long, 3 press; n=-1 on timeout
   task automatic wait_for(input int which, input int ch, input int maxc, output int n);
      logic [N-1:0] v;
      n = -1;
      for (int i = 1; i <= maxc; i++) begin
         tick();
         case (which)
            0:       v = butd;
            1:       v = ~butd;
            2:       v = long;
            default: v = press;
         endcase
         if (v[ch]) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      but   = 4'b1000;
      repeat (3) tick();
      checks++; if (butd !== 4'b0000) begin failures++; $display("FAIL reset_butd got=%b exp=0000", butd); end
      checks++; if (press !== 4'b0000) begin failures++; $display("FAIL reset_press got=%b exp=0000", press); end
      checks++; if (rel !== 4'b0000) begin failures++; $display("FAIL reset_rel got=%b exp=0000", rel); end
      checks++; if (long !== 4'b0000) begin failures++; $display("FAIL reset_long got=%b exp=0000", long); end
      checks++; if (long_held !== 4'b0000) begin failures++; $display("FAIL reset_long_held got=%b exp=0000", long_held); end
      rst_n = 1'b1;
      repeat (5) tick();
   endtask

   task automatic test_press();
      int n, p0, r0, others;
      p0 = press_cnt[0]; r0 = rel_cnt[0];
      others = press_cnt[1] + press_cnt[2] + press_cnt[3] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3];
      but[0] = 1'b1;
      wait_for(0, 0, 200, n);
      checks++; if (n !== 122) begin failures++; $display("FAIL press_latency got=%0d exp=122", n); end
      checks++; if (press !== 4'b0001) begin failures++; $display("FAIL press_strobe got=%b exp=0001", press); end
      tick();
      checks++; if (press !== 4'b0000) begin failures++; $display("FAIL press_one_cycle got=%b exp=0000", press); end
      checks++; if (butd !== 4'b0001) begin failures++; $display("FAIL press_butd got=%b exp=0001", butd); end
      but[0] = 1'b0;
      wait_for(1, 0, 200, n);
      checks++; if (n !== 122) begin failures++; $display("FAIL release_latency got=%0d exp=122", n); end
      checks++; if (rel !== 4'b0001) begin failures++; $display("FAIL release_strobe got=%b exp=0001", rel); end
      tick();
      checks++; if (press_cnt[0] - p0 !== 1 || rel_cnt[0] - r0 !== 1) begin
         failures++; $display("FAIL press_counts got=%0d/%0d exp=1/1", press_cnt[0] - p0, rel_cnt[0] - r0);
      end
      checks++; if (press_cnt[1] + press_cnt[2] + press_cnt[3] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] !== others) begin
         failures++; $display("FAIL press_quiet_channels got=%0d exp=%0d",
            press_cnt[1] + press_cnt[2] + press_cnt[3] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], others);
      end
   endtask

   task automatic test_bounce();
      int n, bad, p1, r1;
      bad = 0; p1 = press_cnt[1]; r1 = rel_cnt[1];
      for (int i = 0; i < 30; i++) begin
         but[1] = 1'($urandom_range(0, 1));
         tick();
         if (butd[1]) bad++;
      end
      but[1] = 1'b0;
      tick();
      if (butd[1]) bad++;
      but[1] = 1'b1;
      wait_for(0, 1, 200, n);
      checks++; if (bad !== 0) begin failures++; $display("FAIL bounce_press_stable got=%0d exp=0", bad); end
      checks++; if (n !== 122) begin failures++; $display("FAIL bounce_press_latency got=%0d exp=122", n); end
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         but[1] = 1'($urandom_range(0, 1));
         tick();
         if (!butd[1]) bad++;
      end
      but[1] = 1'b1;
      tick();
      but[1] = 1'b0;
      wait_for(1, 1, 200, n);
      checks++; if (bad !== 0) begin failures++; $display("FAIL bounce_release_stable got=%0d exp=0", bad); end
      checks++; if (n !== 122) begin failures++; $display("FAIL bounce_release_latency got=%0d exp=122", n); end
      tick();
      checks++; if (press_cnt[1] - p1 !== 1 || rel_cnt[1] - r1 !== 1) begin
         failures++; $display("FAIL bounce_counts got=%0d/%0d exp=1/1", press_cnt[1] - p1, rel_cnt[1] - r1);
      end
   endtask

   task automatic test_glitch();
      int n;
      but[2] = 1'b1;
      repeat (119) tick();
      but[2] = 1'b0;
      tick();
      but[2] = 1'b1;
      wait_for(0, 2, 200, n);
      checks++; if (n !== 122) begin failures++; $display("FAIL glitch_restart got=%0d exp=122", n); end
      but[2] = 1'b0;
      wait_for(1, 2, 200, n);
      checks++; if (n !== 122) begin failures++; $display("FAIL glitch_release got=%0d exp=122", n); end
   endtask

   task automatic test_long();
      int n, l1;
      l1 = long_cnt[1];
      but[1] = 1'b1;
      wait_for(0, 1, 200, n);
      checks++; if (n !== 122) begin failures++; $display("FAIL long_press_latency got=%0d exp=122", n); end
      wait_for(2, 1, 700, n);
      checks++; if (n !== 600) begin failures++; $display("FAIL long_delay got=%0d exp=600", n); end
      checks++; if (long_held[1] !== 1'b1) begin failures++; $display("FAIL long_held_set got=%b exp=1", long_held[1]); end
      tick();
      checks++; if (long[1] !== 1'b0) begin failures++; $display("FAIL long_one_cycle got=%b exp=0", long[1]); end
      repeat (99) tick();
      but[1] = 1'b0;
      checks++; if (long_held[1] !== 1'b1) begin failures++; $display("FAIL long_held_kept got=%b exp=1", long_held[1]); end
      wait_for(1, 1, 200, n);
      checks++; if (rel[1] !== 1'b1 || long_held[1] !== 1'b0) begin
         failures++; $display("FAIL long_held_clear got=rel%b/held%b exp=rel1/held0", rel[1], long_held[1]);
      end
      tick();
      checks++; if (long_cnt[1] - l1 !== 1) begin failures++; $display("FAIL long_count got=%0d exp=1", long_cnt[1] - l1); end
      but[1] = 1'b1;
      wait_for(0, 1, 200, n);
      repeat (378) tick();
      but[1] = 1'b0;
      wait_for(1, 1, 200, n);
      tick();
      checks++; if (long_cnt[1] - l1 !== 1 || long_held[1] !== 1'b0) begin
         failures++; $display("FAIL short_hold_no_long got=%0d/%b exp=1/0", long_cnt[1] - l1, long_held[1]);
      end
   endtask

   task automatic test_invert();
      int n;
      but[3] = 1'b0;
      wait_for(0, 3, 200, n);
      checks++; if (n !== 122 || press[3] !== 1'b1) begin
         failures++; $display("FAIL invert_press got=%0d/%b exp=122/1", n, press[3]);
      end
      but[3] = 1'b1;
      wait_for(1, 3, 200, n);
      checks++; if (n !== 122 || rel[3] !== 1'b1) begin
         failures++; $display("FAIL invert_release got=%0d/%b exp=122/1", n, rel[3]);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      but[1:0] = 2'b11;
      wait_for(0, 0, 200, n);
      checks++; if (n !== 122 || press !== 4'b0011) begin
         failures++; $display("FAIL simul_press got=%0d/%b exp=122/0011", n, press);
      end
      but[1:0] = 2'b00;
      wait_for(1, 0, 200, n);
      checks++; if (n !== 122 || rel !== 4'b0011) begin
         failures++; $display("FAIL simul_release got=%0d/%b exp=122/0011", n, rel);
      end
   endtask

   task automatic test_reset_mid_hold();
      int n;
      but[2] = 1'b1;
      wait_for(0, 2, 200, n);
      repeat (300) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (butd !== 4'b0000 || long_held !== 4'b0000 || press !== 4'b0000) begin
         failures++; $display("FAIL async_reset got=%b/%b/%b exp=0000", butd, long_held, press);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      wait_for(0, 2, 200, n);
      checks++; if (n !== 122 || press[2] !== 1'b1) begin
         failures++; $display("FAIL requalify_press got=%0d/%b exp=122/1", n, press[2]);
      end
      wait_for(2, 2, 700, n);
      checks++; if (n !== 600) begin failures++; $display("FAIL requalify_long got=%0d exp=600", n); end
      but[2] = 1'b0;
      wait_for(1, 2, 200, n);
      tick();
   endtask

   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_glitch();
      test_long();
      test_invert();
      test_back_to_back();
      test_reset_mid_hold();
      checks++; if (both_cnt !== 0) begin failures++; $display("FAIL press_rel_overlap got=%0d exp=0", both_cnt); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
